acc_control_fsm: RTL and testbench

- Multicycle main controller for the 16-bit accumulator CPU.
- Decodes the IR opcode and sequences the PC, memory, wires and ALU subsystems by driving every control line they consume.
- Sits beside the memory subsystem in the top level; memory accesses obey a ready handshake so wait-state memories can be used.

---
 rtl/acc_pkg.sv | 95 +++++++++
 rtl/acc_mem_wait.sv | 32 +++
 rtl/acc_control_fsm.sv | 218 +++++++++++++++++++++
 tb/tb_acc_control_fsm.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared encodings for the 16-bit accumulator CPU: opcodes, datapath select
// codes, controller state codes and the control-line bundle.
package acc_pkg;

   localparam logic [3:0] OP_ADD   = 4'h0;
   localparam logic [3:0] OP_SUB   = 4'h1;
   localparam logic [3:0] OP_AND   = 4'h2;
   localparam logic [3:0] OP_OR    = 4'h3;
   localparam logic [3:0] OP_ADDI  = 4'h4;
   localparam logic [3:0] OP_LOAD  = 4'h5;
   localparam logic [3:0] OP_STORE = 4'h6;
   localparam logic [3:0] OP_BEQ   = 4'h7;
   localparam logic [3:0] OP_BNE   = 4'h8;
   localparam logic [3:0] OP_JUMP  = 4'h9;
   localparam logic [3:0] OP_PUSH  = 4'hA;
   localparam logic [3:0] OP_POP   = 4'hB;
   localparam logic [3:0] OP_IN    = 4'hC;
   localparam logic [3:0] OP_OUT   = 4'hD;
   localparam logic [3:0] OP_ILL   = 4'hE;
   localparam logic [3:0] OP_HLT   = 4'hF;

   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_ZE     = 2'd2;

   localparam logic [1:0] ACCSRC_ALU   = 2'd0;
   localparam logic [1:0] ACCSRC_MDR   = 2'd1;
   localparam logic [1:0] ACCSRC_MEMIN = 2'd2;

   localparam logic [1:0] SRCA_PC  = 2'd0;
   localparam logic [1:0] SRCA_ACC = 2'd1;
   localparam logic [1:0] SRCA_SP  = 2'd2;

   localparam logic [2:0] SRCB_TWO    = 3'd0;
   localparam logic [2:0] SRCB_MDR    = 3'd1;
   localparam logic [2:0] SRCB_SE     = 3'd2;
   localparam logic [2:0] SRCB_SELEFT = 3'd3;
   localparam logic [2:0] SRCB_ZERO   = 3'd4;

   localparam logic [2:0] ALU_ADD   = 3'd0;
   localparam logic [2:0] ALU_SUB   = 3'd1;
   localparam logic [2:0] ALU_AND   = 3'd2;
   localparam logic [2:0] ALU_OR    = 3'd3;
   localparam logic [2:0] ALU_PASSA = 3'd4;

   localparam logic [1:0] MADDR_PC = 2'd0;
   localparam logic [1:0] MADDR_ZE = 2'd1;
   localparam logic [1:0] MADDR_SP = 2'd2;

   typedef logic [4:0] state_t;

   localparam state_t S_IDLE   = 5'd0;
   localparam state_t S_FETCH  = 5'd1;
   localparam state_t S_DECODE = 5'd2;
   localparam state_t S_MEMRD  = 5'd3;
   localparam state_t S_ALUMEM = 5'd4;
   localparam state_t S_ALUIMM = 5'd5;
   localparam state_t S_LDWB   = 5'd6;
   localparam state_t S_STORE  = 5'd7;
   localparam state_t S_BRANCH = 5'd8;
   localparam state_t S_JUMP   = 5'd9;
   localparam state_t S_PUSH1  = 5'd10;
   localparam state_t S_PUSH2  = 5'd11;
   localparam state_t S_POP1   = 5'd12;
   localparam state_t S_POP2   = 5'd13;
   localparam state_t S_IN     = 5'd14;
   localparam state_t S_OUT    = 5'd15;
   localparam state_t S_HALT   = 5'd16;

   typedef struct packed {
      logic       pc_write;
      logic       branch;
      logic       bne_or_beq;
      logic [1:0] pc_src;
      logic       acc_write;
      logic [1:0] acc_src;
      logic       sp_write;
      logic [1:0] alu_src_a;
      logic [2:0] alu_src_b;
      logic [2:0] alu_op;
      logic       mem_read;
      logic       mem_write;
      logic [1:0] mem_addr_src;
      logic       ir_write;
      logic       out_write;
      logic       halted;
   } ctrl_t;

   // States that wait on the memory ready handshake.
   function automatic logic is_mem_state(input state_t s);
      return (s == S_FETCH) || (s == S_MEMRD) || (s == S_STORE) ||
             (s == S_PUSH2) || (s == S_POP1);
   endfunction

endpackage

// File: rtl/acc_mem_wait.sv
// Wait-state counter for one memory access; flags a bus timeout once
// MAX_WAIT not-ready cycles have elapsed and the memory is still not ready.
module acc_mem_wait #(
   parameter int MAX_WAIT = 15
) (
   input  logic CLK,
   input  logic reset,
   input  logic in_mem_state,
   input  logic mem_ready,
   output logic timeout
);

   localparam int CW = $clog2(MAX_WAIT + 1);

   logic [CW-1:0] r_wait_cnt;

   // Count not-ready cycles; any completed access or non-memory state clears it.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         r_wait_cnt <= '0;
      end else if (!in_mem_state || mem_ready) begin
         r_wait_cnt <= '0;
      end else if (r_wait_cnt != CW'(MAX_WAIT)) begin
         r_wait_cnt <= r_wait_cnt + CW'(1);
      end else begin
         r_wait_cnt <= r_wait_cnt;
      end
   end

   assign timeout = in_mem_state && !mem_ready && (r_wait_cnt == CW'(MAX_WAIT));

endmodule

// File: rtl/acc_control_fsm.sv
// Multicycle main controller of the accumulator CPU: sequences fetch, decode,
// memory, ALU and PC updates, with wait-state memory and bus-error halt.
module acc_control_fsm
   import acc_pkg::*;
#(
   parameter int OPW      = 4,
   parameter int MAX_WAIT = 15
) (
   input  logic           CLK,
   input  logic           reset,
   input  logic           run,
   input  logic [OPW-1:0] opcode,
   input  logic           zero,
   input  logic           mem_ready,
   output logic           PCWrite,
   output logic           Branch,
   output logic           bneOrbeq,
   output logic [1:0]     PCSrc,
   output logic           AccWrite,
   output logic [1:0]     AccSrc,
   output logic           SpWrite,
   output logic [1:0]     ALUSrcA,
   output logic [2:0]     ALUSrcB,
   output logic [2:0]     ALUOp,
   output logic           MemRead,
   output logic           MemWrite,
   output logic [1:0]     MemAddrSrc,
   output logic           IRWrite,
   output logic           OutWrite,
   output logic           halted,
   output logic           err
);

   state_t r_state;
   state_t w_next;
   logic   r_err;
   logic   w_err_set;
   logic   w_timeout;
   ctrl_t  w_ctrl;
   logic   w_unused_zero;

   // The zero flag is consumed by the PC block, not by the sequencer.
   assign w_unused_zero = zero;

   acc_mem_wait #(.MAX_WAIT(MAX_WAIT)) u_mem_wait (
      .CLK          (CLK),
      .reset        (reset),
      .in_mem_state (is_mem_state(r_state)),
      .mem_ready    (mem_ready),
      .timeout      (w_timeout)
   );

   function automatic state_t mem_next(input logic tmo, input logic rdy,
                                       input state_t cur, input state_t done);
      if (tmo) begin
         return S_HALT;
      end else if (rdy) begin
         return done;
      end else begin
         return cur;
      end
   endfunction

   // Next-state selection.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   w_next = run ? S_FETCH : S_IDLE;
         S_FETCH:  w_next = mem_next(w_timeout, mem_ready, S_FETCH, S_DECODE);
         S_DECODE: begin
            case (opcode)
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LOAD: w_next = S_MEMRD;
               OP_ADDI:           w_next = S_ALUIMM;
               OP_STORE:          w_next = S_STORE;
               OP_BEQ, OP_BNE:    w_next = S_BRANCH;
               OP_JUMP:           w_next = S_JUMP;
               OP_PUSH:           w_next = S_PUSH1;
               OP_POP:            w_next = S_POP1;
               OP_IN:             w_next = S_IN;
               OP_OUT:            w_next = S_OUT;
               default:           w_next = S_HALT;
            endcase
         end
         S_MEMRD:  w_next = mem_next(w_timeout, mem_ready, S_MEMRD,
                                     (opcode == OP_LOAD) ? S_LDWB : S_ALUMEM);
         S_STORE:  w_next = mem_next(w_timeout, mem_ready, S_STORE, S_FETCH);
         S_PUSH1:  w_next = S_PUSH2;
         S_PUSH2:  w_next = mem_next(w_timeout, mem_ready, S_PUSH2, S_FETCH);
         S_POP1:   w_next = mem_next(w_timeout, mem_ready, S_POP1, S_POP2);
         S_ALUMEM, S_ALUIMM, S_LDWB, S_BRANCH, S_JUMP, S_POP2, S_IN, S_OUT:
                   w_next = S_FETCH;
         S_HALT:   w_next = S_HALT;
         default:  w_next = S_HALT;
      endcase
   end

   assign w_err_set = w_timeout ||
                      ((r_state == S_DECODE) && (opcode == OP_ILL)) ||
                      (r_state > S_HALT);

   // State and sticky error registers.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_err   <= r_err | w_err_set;
      end
   end

   // Control lines decoded from state; FETCH writes wait for mem_ready.
   always_comb begin
      w_ctrl = '0;
      case (r_state)
         S_FETCH: begin
            w_ctrl.mem_read     = 1'b1;
            w_ctrl.mem_addr_src = MADDR_PC;
            w_ctrl.alu_src_a    = SRCA_PC;
            w_ctrl.alu_src_b    = SRCB_TWO;
            w_ctrl.alu_op       = ALU_ADD;
            w_ctrl.pc_src       = PCSRC_ALU;
            w_ctrl.ir_write     = mem_ready;
            w_ctrl.pc_write     = mem_ready;
         end
         S_DECODE: begin
            w_ctrl.alu_src_a = SRCA_PC;
            w_ctrl.alu_src_b = SRCB_SELEFT;
            w_ctrl.alu_op    = ALU_ADD;
         end
         S_MEMRD: begin
            w_ctrl.mem_read     = 1'b1;
            w_ctrl.mem_addr_src = MADDR_ZE;
         end
         S_ALUMEM: begin
            w_ctrl.alu_src_a = SRCA_ACC;
            w_ctrl.alu_src_b = SRCB_MDR;
            w_ctrl.alu_op    = opcode[2:0];
            w_ctrl.acc_write = 1'b1;
            w_ctrl.acc_src   = ACCSRC_ALU;
         end
         S_ALUIMM: begin
            w_ctrl.alu_src_a = SRCA_ACC;
            w_ctrl.alu_src_b = SRCB_SE;
            w_ctrl.alu_op    = ALU_ADD;
            w_ctrl.acc_write = 1'b1;
         end
         S_LDWB: begin
            w_ctrl.acc_write = 1'b1;
            w_ctrl.acc_src   = ACCSRC_MDR;
         end
         S_STORE: begin
            w_ctrl.mem_write    = 1'b1;
            w_ctrl.mem_addr_src = MADDR_ZE;
         end
         S_BRANCH: begin
            w_ctrl.alu_src_a  = SRCA_ACC;
            w_ctrl.alu_src_b  = SRCB_ZERO;
            w_ctrl.alu_op     = ALU_SUB;
            w_ctrl.branch     = 1'b1;
            w_ctrl.bne_or_beq = opcode[3];
            w_ctrl.pc_src     = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            w_ctrl.pc_write = 1'b1;
            w_ctrl.pc_src   = PCSRC_ZE;
         end
         S_PUSH1: begin
            w_ctrl.alu_src_a = SRCA_SP;
            w_ctrl.alu_src_b = SRCB_TWO;
            w_ctrl.alu_op    = ALU_SUB;
            w_ctrl.sp_write  = 1'b1;
         end
         S_PUSH2: begin
            w_ctrl.mem_write    = 1'b1;
            w_ctrl.mem_addr_src = MADDR_SP;
         end
         S_POP1: begin
            w_ctrl.mem_read     = 1'b1;
            w_ctrl.mem_addr_src = MADDR_SP;
         end
         S_POP2: begin
            w_ctrl.acc_write = 1'b1;
            w_ctrl.acc_src   = ACCSRC_MDR;
            w_ctrl.alu_src_a = SRCA_SP;
            w_ctrl.alu_src_b = SRCB_TWO;
            w_ctrl.alu_op    = ALU_ADD;
            w_ctrl.sp_write  = 1'b1;
         end
         S_IN: begin
            w_ctrl.acc_write = 1'b1;
            w_ctrl.acc_src   = ACCSRC_MEMIN;
         end
         S_OUT:   w_ctrl.out_write = 1'b1;
         S_HALT:  w_ctrl.halted    = 1'b1;
         default: w_ctrl = '0;
      endcase
   end

   assign PCWrite    = w_ctrl.pc_write;
   assign Branch     = w_ctrl.branch;
   assign bneOrbeq   = w_ctrl.bne_or_beq;
   assign PCSrc      = w_ctrl.pc_src;
   assign AccWrite   = w_ctrl.acc_write;
   assign AccSrc     = w_ctrl.acc_src;
   assign SpWrite    = w_ctrl.sp_write;
   assign ALUSrcA    = w_ctrl.alu_src_a;
   assign ALUSrcB    = w_ctrl.alu_src_b;
   assign ALUOp      = w_ctrl.alu_op;
   assign MemRead    = w_ctrl.mem_read;
   assign MemWrite   = w_ctrl.mem_write;
   assign MemAddrSrc = w_ctrl.mem_addr_src;
   assign IRWrite    = w_ctrl.ir_write;
   assign OutWrite   = w_ctrl.out_write;
   assign halted     = w_ctrl.halted;
   assign err        = r_err;

endmodule

// File: tb/tb_acc_control_fsm.sv
// Bench for acc_control_fsm: directed vector table, hand-written corner
// sequences, and random instruction streams against an instruction-level model.
module tb_acc_control_fsm;

   logic       CLK, reset, run, zero, mem_ready;
   logic [3:0] opcode;
   logic       PCWrite, Branch, bneOrbeq, AccWrite, SpWrite;
   logic       MemRead, MemWrite, IRWrite, OutWrite, halted, err;
   logic [1:0] PCSrc, AccSrc, ALUSrcA, MemAddrSrc;
   logic [2:0] ALUSrcB, ALUOp;

   typedef struct packed {
      logic       pcw, br, bne;
      logic [1:0] pcsrc;
      logic       accw;
      logic [1:0] accsrc;
      logic       spw;
      logic [1:0] sa;
      logic [2:0] sb;
      logic [2:0] aop;
      logic       mr, mw;
      logic [1:0] mas;
      logic       irw, ow, hl, er;
   } tctl_t;

   typedef enum int {K_FETCH, K_DECODE, K_MEMRD, K_ALUMEM, K_ALUIMM, K_LDWB,
                     K_STORE, K_BRANCH, K_JUMP, K_PUSH1, K_PUSH2, K_POP1,
                     K_POP2, K_IN, K_OUT} kind_e;

   typedef struct {
      logic       run;
      logic [3:0] op;
      logic       mr;
      tctl_t      exp;
      string      nm;
   } vec_t;

   tctl_t act;
   int    n_chk = 0;
   int    n_fail = 0;
   vec_t  tbl[$];
   kind_e seq[$];

   acc_control_fsm #(.OPW(4), .MAX_WAIT(15)) dut (
      .CLK(CLK), .reset(reset), .run(run), .opcode(opcode), .zero(zero),
      .mem_ready(mem_ready), .PCWrite(PCWrite), .Branch(Branch),
      .bneOrbeq(bneOrbeq), .PCSrc(PCSrc), .AccWrite(AccWrite), .AccSrc(AccSrc),
      .SpWrite(SpWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .MemRead(MemRead), .MemWrite(MemWrite), .MemAddrSrc(MemAddrSrc),
      .IRWrite(IRWrite), .OutWrite(OutWrite), .halted(halted), .err(err)
   );

   assign act = {PCWrite, Branch, bneOrbeq, PCSrc, AccWrite, AccSrc, SpWrite,
                 ALUSrcA, ALUSrcB, ALUOp, MemRead, MemWrite, MemAddrSrc,
                 IRWrite, OutWrite, halted, err};

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Control lines each micro-step of the instruction set must show.
   function automatic tctl_t ctl_of(input kind_e k, input logic [3:0] op);
      tctl_t t;
      t = '0;
      case (k)
         K_FETCH:  begin t.mr = 1'b1; t.irw = 1'b1; t.pcw = 1'b1; end
         K_DECODE: t.sb = 3'd3;
         K_MEMRD:  begin t.mr = 1'b1; t.mas = 2'd1; end
         K_ALUMEM: begin t.sa = 2'd1; t.sb = 3'd1; t.aop = op[2:0]; t.accw = 1'b1; end
         K_ALUIMM: begin t.sa = 2'd1; t.sb = 3'd2; t.accw = 1'b1; end
         K_LDWB:   begin t.accw = 1'b1; t.accsrc = 2'd1; end
         K_STORE:  begin t.mw = 1'b1; t.mas = 2'd1; end
         K_BRANCH: begin t.sa = 2'd1; t.sb = 3'd4; t.aop = 3'd1; t.br = 1'b1;
                         t.bne = op[3]; t.pcsrc = 2'd1; end
         K_JUMP:   begin t.pcw = 1'b1; t.pcsrc = 2'd2; end
         K_PUSH1:  begin t.sa = 2'd2; t.aop = 3'd1; t.spw = 1'b1; end
         K_PUSH2:  begin t.mw = 1'b1; t.mas = 2'd2; end
         K_POP1:   begin t.mr = 1'b1; t.mas = 2'd2; end
         K_POP2:   begin t.accw = 1'b1; t.accsrc = 2'd1; t.sa = 2'd2; t.spw = 1'b1; end
         K_IN:     begin t.accw = 1'b1; t.accsrc = 2'd2; end
         K_OUT:    t.ow = 1'b1;
         default:  t = '0;
      endcase
      return t;
   endfunction

   function automatic tctl_t gate(input tctl_t t);
      tctl_t g;
      g = t;
      g.pcw = 1'b0; g.irw = 1'b0; g.accw = 1'b0; g.spw = 1'b0;
      return g;
   endfunction

   function automatic bit is_mem(input kind_e k);
      return (k == K_FETCH) || (k == K_MEMRD) || (k == K_STORE) ||
             (k == K_PUSH2) || (k == K_POP1);
   endfunction

   function automatic tctl_t halt_ctl(input logic e);
      tctl_t t;
      t = '0;
      t.hl = 1'b1;
      t.er = e;
      return t;
   endfunction

   // Micro-step sequence an instruction walks through.
   task automatic build(input logic [3:0] op);
      seq = {K_FETCH, K_DECODE};
      case (op)
         4'h0, 4'h1, 4'h2, 4'h3: begin seq.push_back(K_MEMRD); seq.push_back(K_ALUMEM); end
         4'h4: seq.push_back(K_ALUIMM);
         4'h5: begin seq.push_back(K_MEMRD); seq.push_back(K_LDWB); end
         4'h6: seq.push_back(K_STORE);
         4'h7, 4'h8: seq.push_back(K_BRANCH);
         4'h9: seq.push_back(K_JUMP);
         4'hA: begin seq.push_back(K_PUSH1); seq.push_back(K_PUSH2); end
         4'hB: begin seq.push_back(K_POP1); seq.push_back(K_POP2); end
         4'hC: seq.push_back(K_IN);
         default: seq.push_back(K_OUT);
      endcase
   endtask

   task automatic chk(input string nm, input tctl_t exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", nm, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic [3:0] op, input logic mr,
                       input tctl_t exp, input string nm);
      run = r; opcode = op; mem_ready = mr;
      @(negedge CLK);
      chk(nm, exp);
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0; run = 1'b0; mem_ready = 1'b0;
      #1;
      chk("reset_state", '0);
      @(posedge CLK);
      #1;
      reset = 1'b1;
   endtask

   task automatic add(input logic r, input logic [3:0] op, input logic mr,
                      input tctl_t exp, input string nm);
      vec_t v;
      v.run = r; v.op = op; v.mr = mr; v.exp = exp; v.nm = nm;
      tbl.push_back(v);
   endtask

   initial begin
      reset = 1'b0; run = 1'b0; zero = 1'b0; mem_ready = 1'b0; opcode = 4'h0;

      add(1'b1, 4'h0, 1'b0, '0, "idle_run");
      add(1'b0, 4'h4, 1'b0, gate(ctl_of(K_FETCH, 4'h4)), "fetch_wait");
      add(1'b0, 4'h4, 1'b1, ctl_of(K_FETCH, 4'h4), "addi_fetch");
      add(1'b0, 4'h4, 1'b1, ctl_of(K_DECODE, 4'h4), "addi_decode");
      add(1'b0, 4'h4, 1'b1, ctl_of(K_ALUIMM, 4'h4), "addi_exec");
      add(1'b0, 4'h5, 1'b1, ctl_of(K_FETCH, 4'h5), "ld_fetch");
      add(1'b0, 4'h5, 1'b0, ctl_of(K_DECODE, 4'h5), "ld_decode");
      add(1'b0, 4'h5, 1'b0, ctl_of(K_MEMRD, 4'h5), "ld_memrd_w1");
      add(1'b0, 4'h5, 1'b0, ctl_of(K_MEMRD, 4'h5), "ld_memrd_w2");
      add(1'b0, 4'h5, 1'b1, ctl_of(K_MEMRD, 4'h5), "ld_memrd_rdy");
      add(1'b0, 4'h5, 1'b1, ctl_of(K_LDWB, 4'h5), "ld_wb");
      add(1'b0, 4'h7, 1'b1, ctl_of(K_FETCH, 4'h7), "beq_fetch");
      add(1'b0, 4'h7, 1'b1, ctl_of(K_DECODE, 4'h7), "beq_decode");
      add(1'b0, 4'h7, 1'b1, ctl_of(K_BRANCH, 4'h7), "beq_branch");
      add(1'b0, 4'h8, 1'b1, ctl_of(K_FETCH, 4'h8), "bne_fetch");
      add(1'b0, 4'h8, 1'b1, ctl_of(K_DECODE, 4'h8), "bne_decode");
      add(1'b0, 4'h8, 1'b1, ctl_of(K_BRANCH, 4'h8), "bne_branch");
      add(1'b0, 4'hA, 1'b1, ctl_of(K_FETCH, 4'hA), "push_fetch");
      add(1'b0, 4'hA, 1'b1, ctl_of(K_DECODE, 4'hA), "push_decode");
      add(1'b0, 4'hA, 1'b0, ctl_of(K_PUSH1, 4'hA), "push1");
      add(1'b0, 4'hA, 1'b1, ctl_of(K_PUSH2, 4'hA), "push2");
      add(1'b0, 4'hB, 1'b1, ctl_of(K_FETCH, 4'hB), "pop_fetch");
      add(1'b0, 4'hB, 1'b1, ctl_of(K_DECODE, 4'hB), "pop_decode");
      add(1'b0, 4'hB, 1'b1, ctl_of(K_POP1, 4'hB), "pop1");
      add(1'b0, 4'hB, 1'b1, ctl_of(K_POP2, 4'hB), "pop2");
      add(1'b1, 4'hB, 1'b0, gate(ctl_of(K_FETCH, 4'hB)), "after_pop_fetch");

      do_reset();
      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].run, tbl[i].op, tbl[i].mr, tbl[i].exp, tbl[i].nm);
      end

      // Illegal opcode: sticky error halt that ignores run.
      do_reset();
      step(1'b1, 4'hE, 1'b1, '0, "ill_idle");
      step(1'b0, 4'hE, 1'b1, ctl_of(K_FETCH, 4'hE), "ill_fetch");
      step(1'b0, 4'hE, 1'b1, ctl_of(K_DECODE, 4'hE), "ill_decode");
      for (int i = 0; i < 4; i++) step(i[0] ? 1'b1 : 1'b0, 4'h4, 1'b1, halt_ctl(1'b1), "ill_halt");

      // Fetch that never completes: 16 not-ready cycles, then bus-error halt.
      do_reset();
      step(1'b1, 4'h0, 1'b0, '0, "tmo_idle");
      for (int i = 0; i < 16; i++) step(1'b0, 4'h0, 1'b0, gate(ctl_of(K_FETCH, 4'h0)), "tmo_fetch_wait");
      for (int i = 0; i < 3; i++) step(1'b1, 4'h0, 1'b0, halt_ctl(1'b1), "tmo_halt");

      // Reset in the middle of a stalled PUSH2.
      do_reset();
      step(1'b1, 4'hA, 1'b0, '0, "rst_idle");
      step(1'b0, 4'hA, 1'b1, ctl_of(K_FETCH, 4'hA), "rst_fetch");
      step(1'b0, 4'hA, 1'b1, ctl_of(K_DECODE, 4'hA), "rst_decode");
      step(1'b0, 4'hA, 1'b0, ctl_of(K_PUSH1, 4'hA), "rst_push1");
      mem_ready = 1'b0;
      @(negedge CLK);
      chk("rst_push2_stall", ctl_of(K_PUSH2, 4'hA));
      #2;
      reset = 1'b0;
      #1;
      chk("rst_immediate", '0);
      mem_ready = 1'b1;
      @(posedge CLK);
      #1;
      chk("rst_held", '0);
      reset = 1'b1;
      step(1'b0, 4'hA, 1'b1, '0, "rst_no_write1");
      step(1'b1, 4'hA, 1'b1, '0, "rst_no_write2");
      step(1'b0, 4'hA, 1'b1, ctl_of(K_FETCH, 4'hA), "rst_restart_fetch");

      // Random instruction streams with random wait states.
      do_reset();
      step(1'b1, 4'h0, 1'b0, '0, "rnd_idle");
      for (int n = 0; n < 150; n++) begin
         logic [3:0] op;
         op = 4'($urandom_range(0, 13));
         build(op);
         foreach (seq[k]) begin
            tctl_t e;
            e = ctl_of(seq[k], op);
            if (is_mem(seq[k])) begin
               int w;
               if ($urandom_range(0, 15) == 0) w = 15;
               else if ($urandom_range(0, 2) == 0) w = int'($urandom_range(1, 3));
               else w = 0;
               for (int j = 0; j < w; j++)
                  step(1'($urandom_range(0, 1)), op, 1'b0, gate(e), "rnd_wait");
               step(1'($urandom_range(0, 1)), op, 1'b1, e, "rnd_mem");
            end else begin
               step(1'($urandom_range(0, 1)), op, 1'($urandom_range(0, 1)), e, "rnd_step");
            end
         end
      end
      step(1'b1, 4'hF, 1'b1, ctl_of(K_FETCH, 4'hF), "hlt_fetch");
      step(1'b1, 4'hF, 1'b1, ctl_of(K_DECODE, 4'hF), "hlt_decode");
      for (int i = 0; i < 3; i++) step(1'b1, 4'hF, 1'b1, halt_ctl(1'b0), "hlt_halt");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
